// File: rtl/fib_pkg.sv
// Shared frame definitions for the Fibonacci unroller: a frame is a 2-bit
// continuation code on top of a 126-bit operand.
package fib_pkg;

    localparam int FRAME_W = 128;
    localparam int CCODE_W = 2;
    localparam int VAL_W   = FRAME_W - CCODE_W;

    localparam logic [CCODE_W-1:0] CC_DONE  = 2'b00;
    localparam logic [CCODE_W-1:0] CC_LEFT  = 2'b01;
    localparam logic [CCODE_W-1:0] CC_RIGHT = 2'b10;

    typedef struct packed {
        logic [CCODE_W-1:0] ccode;
        logic [VAL_W-1:0]   value;
    } frame_t;

    function automatic frame_t make_frame(input logic [CCODE_W-1:0] ccode,
                                          input logic [VAL_W-1:0]   value);
        frame_t f;
        f.ccode = ccode;
        f.value = value;
        return f;
    endfunction

endpackage

// File: rtl/fib_stack_mem.sv
// Frame storage: synchronous write, registered read. A read and a write to the
// same address on one edge return the old contents (used by replace-top).
module fib_stack_mem
    import fib_pkg::*;
#(
    parameter int WIDTH  = FRAME_W,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array has no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fib_call_stack.sv
// LIFO frame stack for the Fibonacci datapath: push/pop/tos with registered
// top-of-stack output and sticky error flags. Optional hwm port under FIB_STACK_HWM_EN.
module fib_call_stack
    import fib_pkg::*;
#(
    parameter int WIDTH = FRAME_W,
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
`ifdef FIB_STACK_HWM_EN
    ,
    output logic [CNT_W-1:0] hwm
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  count_dec;
    logic [ADDR_W-1:0] top_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              mem_we;
    logic              mem_re;
    logic              set_ovf;
    logic              set_unf;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign count_dec = count - 1'b1;
    assign top_addr  = count_dec[ADDR_W-1:0];

    // Pop dominates tos; both read the pre-edge top, so replace-top returns the
    // old frame while the same slot is overwritten.
    always_comb begin
        count_next = count;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        wr_addr    = count[ADDR_W-1:0];
        set_ovf    = 1'b0;
        set_unf    = 1'b0;

        if (pop) begin
            if (empty) begin
                set_unf = 1'b1;
                if (push) begin
                    mem_we     = 1'b1;
                    count_next = count + 1'b1;
                end
            end else begin
                mem_re = 1'b1;
                if (push) begin
                    mem_we  = 1'b1;
                    wr_addr = top_addr;
                end else begin
                    count_next = count_dec;
                end
            end
        end else begin
            mem_re = tos && !empty;
            if (push) begin
                if (full) begin
                    set_ovf = 1'b1;
                end else begin
                    mem_we     = 1'b1;
                    count_next = count + 1'b1;
                end
            end
        end
    end

    fib_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .waddr(wr_addr),
        .wdata(d_in),
        .re   (mem_re),
        .raddr(top_addr),
        .rdata(d_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // A fresh error on the same edge outranks clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (set_ovf) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (set_unf) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef FIB_STACK_HWM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hwm <= '0;
        end else if (count_next > hwm) begin
            hwm <= count_next;
        end
    end
`endif

endmodule

// File: doc/fib_call_stack.md
# fib_call_stack

LIFO responder that serves the push/pop/tos requests issued by `fib_datapath` while it unrolls the recursive Fibonacci evaluation. Each 128-bit frame holds a 2-bit continuation code in bits [127:126] and a 126-bit operand. The stack stores frames verbatim, returns the top frame on a registered output, and reports occupancy and protocol errors back to the controller. It sits between the datapath's frame mux and the controller's status inputs.

## Interface
Parameters:
- `WIDTH`, 128, frame width in bits.
- `DEPTH`, 64, maximum number of stored frames (power of two, ≥2).
- `CNT_W`, `$clog2(DEPTH+1)`, occupancy counter width.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `push`  in  1  store `d_in` as the new top.
- `pop`  in  1  remove the top frame and present it on `d_out`.
- `tos`  in  1  present the top frame on `d_out` without removing it.
- `clr_err`  in  1  clear sticky error flags.
- `d_in`  in  WIDTH  frame to push.
- `d_out`  out  WIDTH  registered frame returned by the last successful pop/tos.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `count`  out  CNT_W  current occupancy.
- `overflow`  out  1  sticky: push attempted while full.
- `underflow`  out  1  sticky: pop attempted while empty.

## Operation
- Reset: pointer/count = 0, `d_out` = 0, `empty` = 1, `full` = 0, `overflow` = `underflow` = 0. Memory contents are don't-care.
- Push only: not full → mem[count] ← `d_in`, count+1. Full → frame dropped, count unchanged, `overflow` ← 1.
- Pop only: not empty → `d_out` ← mem[count-1], count-1. Empty → `d_out` unchanged, `underflow` ← 1.
- Tos only, with pop low: not empty → `d_out` ← mem[count-1]. Empty → `d_out` unchanged, no error.
- Pop overrides tos. Tos with pop asserted is ignored.
- Push+pop, not empty: replace-top. `d_out` ← old mem[count-1], mem[count-1] ← `d_in`, count unchanged. Legal when full.
- Push+pop, empty: push proceeds (count 0→1), `underflow` ← 1, `d_out` unchanged.
- Push+tos, pop low: tos returns the pre-edge top. When empty, tos has no effect and the push proceeds.
- `clr_err`: clears both sticky flags. An error detected in the same cycle wins, so the flag stays 1.
- Frames are opaque: no alteration of bits [127:126].

## Timing
- All outputs are registered or decoded from registered count. No combinational path from inputs to outputs.
- `d_out` is valid the cycle after pop/tos is sampled. Latency is 1.
- Back-to-back pops every cycle are supported. Each returns successive lower frames.
- A push followed by pop/tos on the next cycle returns the pushed frame. No bubble.
- `rst` mid-operation: next cycle matches the reset state regardless of other inputs.

## Configuration
- `FIB_STACK_HWM_EN` defined: adds output `hwm` [CNT_W], the maximum count reached since reset.
  - Updated the same edge as count.
  - Cleared only by `rst`, not by `clr_err`.
- Undefined: no `hwm` port and no tracking logic. All other behaviour is identical.

## Structure
- Shared package `fib_pkg`:
  - `FRAME_W` = 128, `CCODE_W` = 2, `VAL_W` = 126.
  - Continuation-code constants: `CC_DONE` = 2'b00, `CC_LEFT` = 2'b01, `CC_RIGHT` = 2'b10.
  - `frame_t` packed struct {ccode, value}.
- One sub-module, `fib_stack_mem`: WIDTH×DEPTH synchronous-write, registered-read array (write addr, read addr, we, re).
- Pointer, count, flag and `d_out` logic live in the top.

## Test plan
- Reset, then tos with no push → `d_out` = 0, `empty` = 1, `underflow` = 0.
- Push 0x1, 0x2, 0x3, then pop ×3 on consecutive cycles → `d_out` = 0x3, 0x2, 0x1 on successive cycles. `empty` = 1 after the third pop. `count` = 3→0.
- Fill DEPTH=64 frames, then push 0xDEAD → `full` = 1, `count` = 64, `overflow` = 1. Pop returns frame #64, not 0xDEAD.
- Push {2'b10, 126'd5}, then push+pop with {2'b01, 126'd7} → `d_out` = {2'b10, 5}, count stays 1. Next pop → {2'b01, 7}.
- Pop on empty → `underflow` = 1. Assert `clr_err` → 0. Assert `clr_err` together with a pop on empty → stays 1.
- With `FIB_STACK_HWM_EN`: push 5, pop 3, push 1 → `hwm` = 5. `rst` → `hwm` = 0.
